// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - sizing helpers shared by the parametrised FIFO and its RAM
package fifo_pkg;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Pointers carry one extra wrap bit, so count spans 0..DEPTH inclusive.
    function automatic int fifo_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - single write port RAM, synchronous write, asynchronous read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with count, programmable flags and optional FWFT
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam int CNT_W = fifo_cnt_w(ADDR_W);
    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LVL);

    if (!(AE_LVL >= 0 && AE_LVL < AF_LVL && AF_LVL <= DEPTH)) begin : g_bad_params
        $error("sync_fifo_param: levels must satisfy 0 <= AE_LVL < AF_LVL <= DEPTH");
    end

    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Registered full/empty gate acceptance, which gives the simultaneous
    // read+write priority rules at both boundaries for free.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_nxt = wr_ptr + CNT_W'(wr_acc);
        rd_ptr_nxt = rd_ptr + CNT_W'(rd_acc);
        cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= cnt_nxt;
            empty        <= (wr_ptr_nxt == rd_ptr_nxt);
            full         <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                            (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
            almost_full  <= (cnt_nxt >= AF_CNT);
            almost_empty <= (cnt_nxt <= AE_CNT);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && rst),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_W-1:0] rd_data_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= ram_rdata;
            end
        end

        assign rd_data = rd_data_q;
    end else begin : g_fwft_read
        // Head word is shown directly; forced to zero while empty so the
        // post-reset value is defined.
        assign rd_data = empty ? '0 : ram_rdata;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized scoreboard bench for default and FWFT FIFO configurations
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Instance A: defaults, registered read
    logic       rst_a = 1'b0, wr_en_a = 1'b0, rd_en_a = 1'b0;
    logic [3:0] wr_data_a = '0, rd_data_a;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [4:0] count_a;

    sync_fifo_param u_dut_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
        .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(unf_a)
    );

    // Instance B: FWFT, 8-bit x 8 entries
    logic       rst_b = 1'b0, wr_en_b = 1'b0, rd_en_b = 1'b0;
    logic [7:0] wr_data_b = '0, rd_data_b;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [3:0] count_b;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LVL(6), .AE_LVL(2), .FWFT(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_data(wr_data_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(unf_b)
    );

    // Reference model: contents as a plain queue, popped words go to the scoreboard.
    logic [3:0] mq_a[$];
    logic [3:0] exp_q_a[$];
    logic [7:0] mq_b[$];
    logic       exp_ovf_a = 1'b0, exp_unf_a = 1'b0, exp_ovf_b = 1'b0, exp_unf_b = 1'b0;
    logic       pend_a = 1'b0, rstd_a = 1'b0, rstd_b = 1'b0;

    always @(posedge clk) begin : model_a
        rstd_a <= !rst_a;
        pend_a <= rst_a && rd_en_a && !empty_a;
        if (!rst_a) begin
            mq_a.delete();
            exp_q_a.delete();
            exp_ovf_a <= 1'b0;
            exp_unf_a <= 1'b0;
        end else begin
            exp_ovf_a <= wr_en_a && (mq_a.size() == 16);
            exp_unf_a <= rd_en_a && (mq_a.size() == 0);
            if (wr_en_a && rd_en_a && mq_a.size() == 16) begin
                exp_q_a.push_back(mq_a.pop_front());
            end else begin
                if (rd_en_a && mq_a.size() > 0) exp_q_a.push_back(mq_a.pop_front());
                if (wr_en_a && mq_a.size() < 16) mq_a.push_back(wr_data_a);
            end
        end
    end

    always @(posedge clk) begin : model_b
        rstd_b <= !rst_b;
        if (!rst_b) begin
            mq_b.delete();
            exp_ovf_b <= 1'b0;
            exp_unf_b <= 1'b0;
        end else begin
            exp_ovf_b <= wr_en_b && (mq_b.size() == 8);
            exp_unf_b <= rd_en_b && (mq_b.size() == 0);
            if (wr_en_b && rd_en_b && mq_b.size() == 8) begin
                void'(mq_b.pop_front());
            end else begin
                if (rd_en_b && mq_b.size() > 0) void'(mq_b.pop_front());
                if (wr_en_b && mq_b.size() < 8) mq_b.push_back(wr_data_b);
            end
        end
    end

    always @(negedge clk) begin : monitor_a
        chk("count_a", 32'(count_a), mq_a.size());
        chk("full_a", 32'(full_a), 32'(mq_a.size() == 16));
        chk("empty_a", 32'(empty_a), 32'(mq_a.size() == 0));
        chk("almost_full_a", 32'(af_a), 32'(mq_a.size() >= 14));
        chk("almost_empty_a", 32'(ae_a), 32'(mq_a.size() <= 2));
        chk("overflow_a", 32'(ovf_a), 32'(exp_ovf_a));
        chk("underflow_a", 32'(unf_a), 32'(exp_unf_a));
        if (rstd_a) chk("rd_data_rst_a", 32'(rd_data_a), 0);
        if (pend_a) begin
            if (exp_q_a.size() == 0) chk("scoreboard_word_a", 0, 1);
            else chk("rd_data_a", 32'(rd_data_a), 32'(exp_q_a.pop_front()));
        end
    end

    always @(negedge clk) begin : monitor_b
        chk("count_b", 32'(count_b), mq_b.size());
        chk("full_b", 32'(full_b), 32'(mq_b.size() == 8));
        chk("empty_b", 32'(empty_b), 32'(mq_b.size() == 0));
        chk("almost_full_b", 32'(af_b), 32'(mq_b.size() >= 6));
        chk("almost_empty_b", 32'(ae_b), 32'(mq_b.size() <= 2));
        chk("overflow_b", 32'(ovf_b), 32'(exp_ovf_b));
        chk("underflow_b", 32'(unf_b), 32'(exp_unf_b));
        if (rstd_b) chk("rd_data_rst_b", 32'(rd_data_b), 0);
        if (!empty_b && mq_b.size() > 0) chk("fwft_head_b", 32'(rd_data_b), 32'(mq_b[0]));
    end

    task automatic cyc_a(input logic w, input logic r, input logic [3:0] d);
        wr_en_a = w; rd_en_a = r; wr_data_a = d;
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic w, input logic r, input logic [7:0] d);
        wr_en_b = w; rd_en_b = r; wr_data_b = d;
        @(negedge clk);
    endtask

    initial begin
        // Reset held with both requests active
        rst_a = 1'b0;
        cyc_a(1, 1, 4'h3);
        cyc_a(1, 1, 4'h3);
        rst_a = 1'b1;
        // Fill, overflow, read back in order
        for (int i = 0; i < 16; i++) cyc_a(1, 0, 4'(i));
        cyc_a(1, 0, 4'hA);
        for (int i = 0; i < 16; i++) cyc_a(0, 1, 4'h0);
        cyc_a(0, 0, 4'h0);
        // Underflow on empty with concurrent write
        cyc_a(1, 1, 4'h5);
        cyc_a(0, 1, 4'h0);
        // Full with concurrent read and write
        for (int i = 0; i < 16; i++) cyc_a(1, 0, 4'($urandom_range(0, 15)));
        cyc_a(1, 1, 4'h7);
        for (int i = 0; i < 15; i++) cyc_a(0, 1, 4'h0);
        // Sustained streaming across pointer wraps
        for (int i = 0; i < 5; i++) cyc_a(1, 0, 4'(i));
        for (int i = 0; i < 70; i++) cyc_a(1, 1, 4'(i + 5));
        for (int i = 0; i < 6; i++) cyc_a(0, 1, 4'h0);
        // Random traffic with phases biased toward full and toward empty
        for (int i = 0; i < 800; i++) begin
            int pw;
            pw = ((i / 100) % 2 == 0) ? 80 : 25;
            rst_a = ($urandom_range(0, 149) != 0);
            cyc_a(logic'($urandom_range(0, 99) < pw), logic'($urandom_range(0, 99) < 100 - pw),
                  4'($urandom_range(0, 15)));
        end
        rst_a = 1'b1;
        cyc_a(0, 0, 4'h0);

        // FWFT: head visible without rd_en, pop empties
        rst_b = 1'b1;
        cyc_b(1, 0, 8'hA5);
        cyc_b(0, 0, 8'h00);
        cyc_b(0, 1, 8'h00);
        cyc_b(0, 0, 8'h00);
        // Reset mid-stream discards contents
        cyc_b(1, 0, 8'h11);
        cyc_b(1, 0, 8'h22);
        rst_b = 1'b0;
        cyc_b(1, 1, 8'h33);
        rst_b = 1'b1;
        cyc_b(1, 0, 8'h44);
        cyc_b(0, 0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = ((i / 60) % 2 == 0) ? 75 : 30;
            rst_b = ($urandom_range(0, 119) != 0);
            cyc_b(logic'($urandom_range(0, 99) < pw), logic'($urandom_range(0, 99) < 100 - pw),
                  8'($urandom_range(0, 255)));
        end
        rst_b = 1'b1;
        cyc_b(0, 0, 8'h00);
        cyc_b(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
